// File: rtl/fifo_reader.sv
// Read side of an async FIFO: binary/Gray read pointer, empty flag, fill level,
// and a two-entry output buffer that decouples memory reads from consumer stalls.
module fifo_reader #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                dout_ready,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rclken,
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [ADDRSIZE:0]   rptr_q, rptr_d;
  logic                rempty_q, rempty_d;
  logic [ADDRSIZE:0]   rlevel_q, rlevel_d;
  logic [1:0]          occ_q, occ_d;
  logic [DATASIZE-1:0] buf0_q, buf0_d;  // head entry, drives dout
  logic [DATASIZE-1:0] buf1_q, buf1_d;
  logic                pop;
  logic                push;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A pop frees a slot in the same cycle, so a full buffer can still refill.
  assign pop    = (occ_q != OCC_EMPTY) && dout_ready;
  assign rclken = !rempty_q && ((occ_q != OCC_TWO) || pop);
  assign push   = rclken;

  assign rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, rclken};
  assign rptr_d   = rbin_d ^ (rbin_d >> 1);
  assign rempty_d = (rptr_d == rq2_wptr);
  assign rlevel_d = gray2bin(rq2_wptr) - rbin_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (push && !pop) begin
      if (occ_q == OCC_EMPTY) buf0_d = rdata;
      else                    buf1_d = rdata;
      occ_d = occ_q + 2'd1;
    end else if (!push && pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end else if (push && pop) begin
      if (occ_q == OCC_TWO) begin
        buf0_d = buf1_q;
        buf1_d = rdata;
      end else begin
        buf0_d = rdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  // NOTE: the buffer entries are reset too, because dout must read as zero during reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rlevel_q <= '0;
      occ_q    <= OCC_EMPTY;
      buf0_q   <= '0;
      buf1_q   <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rlevel_q <= rlevel_d;
      occ_q    <= occ_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
    end
  end

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign rlevel     = rlevel_q;
  assign dout       = buf0_q;
  assign dout_valid = (occ_q != OCC_EMPTY);

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a behavioural memory feeds rdata, and the
// write pointer is driven by hand to expose words to the reader.
module tb_fifo_reader;

  logic       rclk;
  logic       rrst_n;
  logic [4:0] rq2_wptr;
  logic [7:0] rdata;
  logic       dout_ready;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rclken;
  logic       rempty;
  logic [7:0] dout;
  logic       dout_valid;
  logic [4:0] rlevel;

  logic [7:0] mem [16];
  logic [7:0] exp_w [32];
  int         n_total = 0;
  int         n_bad   = 0;

  fifo_reader #(.DATASIZE(8), .ADDRSIZE(4)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rq2_wptr   (rq2_wptr),
    .rdata      (rdata),
    .dout_ready (dout_ready),
    .raddr      (raddr),
    .rptr       (rptr),
    .rclken     (rclken),
    .rempty     (rempty),
    .dout       (dout),
    .dout_valid (dout_valid),
    .rlevel     (rlevel)
  );

  assign rdata = mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Holds reset across at least one rising edge, releases it in the low phase.
  task automatic do_reset(input logic [4:0] wptr);
    @(negedge rclk);
    rrst_n     = 1'b0;
    rq2_wptr   = wptr;
    dout_ready = 1'b0;
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // Called in the low phase; samples each cycle and compares popped words to exp_w.
  task automatic drain(input string tag, input int n, input int budget, output int gaps);
    int k   = 0;
    int cyc = 0;
    gaps = 0;
    dout_ready = 1'b1;
    while (k < n && cyc < budget) begin
      #1;
      if (dout_valid) begin
        check($sformatf("%s_w%0d", tag, k), dout, exp_w[k]);
        k++;
      end else if (k > 0) begin
        gaps++;
      end
      cyc++;
      if (k < n) @(negedge rclk);
    end
    if (k < n) check({tag, "_timeout"}, k, n);
  endtask

  initial begin
    int gaps;
    int pulses;
    int moved;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rrst_n     = 1'b1;
    rq2_wptr   = 5'b00000;
    dout_ready = 1'b0;
    #1;
    rrst_n = 1'b0;
    #1;
    check("rst_rempty", rempty, 1);
    check("rst_rclken", rclken, 0);
    check("rst_valid",  dout_valid, 0);
    check("rst_rptr",   rptr, 5'b00000);
    check("rst_rlevel", rlevel, 0);
    check("rst_dout",   dout, 0);
    @(negedge rclk);
    rrst_n = 1'b1;
    repeat (3) @(negedge rclk);
    #1;
    check("idle_rempty", rempty, 1);
    check("idle_rclken", rclken, 0);

    // Three words A0..A2, writer pointer at Gray(3).
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2;
    do_reset(5'b00010);
    dout_ready = 1'b1;
    @(negedge rclk);
    #1;
    check("seq_rempty_fall", rempty, 0);
    check("seq_rlevel", rlevel, 3);
    exp_w[0] = 8'hA0; exp_w[1] = 8'hA1; exp_w[2] = 8'hA2;
    drain("seq", 3, 10, gaps);
    check("seq_gaps", gaps, 0);
    check("seq_rempty_end", rempty, 1);
    check("seq_rptr_end", rptr, 5'b00010);
    @(negedge rclk);
    #1;
    check("seq_valid_end", dout_valid, 0);

    // Backpressure: five words, consumer stalled.
    mem[0] = 8'h50; mem[1] = 8'h51; mem[2] = 8'h52; mem[3] = 8'h53; mem[4] = 8'h54;
    do_reset(5'b00111);
    pulses = 0;
    moved  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk);
      #1;
      if (rclken) pulses++;
      if (dout_valid && dout !== 8'h50) moved = 1;
    end
    check("bp_pulses", pulses, 2);
    check("bp_stable", moved, 0);
    check("bp_dout", dout, 8'h50);
    check("bp_valid", dout_valid, 1);
    check("bp_rlevel", rlevel, 3);

    // One-cycle pop on a full buffer must refill in the same cycle.
    @(negedge rclk);
    dout_ready = 1'b1;
    #1;
    check("refill_rclken", rclken, 1);
    @(negedge rclk);
    dout_ready = 1'b0;
    #1;
    check("refill_dout", dout, 8'h51);
    check("refill_full", rclken, 0);
    check("refill_rlevel", rlevel, 2);
    exp_w[0] = 8'h51; exp_w[1] = 8'h52; exp_w[2] = 8'h53; exp_w[3] = 8'h54;
    drain("bp", 4, 12, gaps);
    @(negedge rclk);
    #1;
    check("bp_empty_end", dout_valid, 0);

    // Wrap: sixteen words, then two more after raddr returns to 0.
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    do_reset(5'b11000);
    dout_ready = 1'b1;
    @(negedge rclk);
    #1;
    check("wrap_rlevel_full", rlevel, 16);
    for (int i = 0; i < 16; i++) exp_w[i] = 8'h10 + 8'(i);
    drain("wrap", 16, 40, gaps);
    check("wrap_gaps", gaps, 0);
    @(negedge rclk);
    #1;
    check("wrap_raddr", raddr, 4'b0000);
    check("wrap_rptr", rptr, 5'b11000);
    check("wrap_rempty", rempty, 1);
    check("wrap_rlevel", rlevel, 0);
    mem[0] = 8'hC0; mem[1] = 8'hC1;
    rq2_wptr = 5'b11011;
    exp_w[0] = 8'hC0; exp_w[1] = 8'hC1;
    drain("wrap2", 2, 12, gaps);
    @(negedge rclk);
    #1;
    check("wrap2_raddr", raddr, 4'b0010);

    // Mid-stream reset with a full buffer.
    mem[0] = 8'h60; mem[1] = 8'h61; mem[2] = 8'h62; mem[3] = 8'h63; mem[4] = 8'h64;
    do_reset(5'b00111);
    repeat (4) @(negedge rclk);
    #1;
    check("mid_pre_rptr", rptr, 5'b00011);
    check("mid_pre_valid", dout_valid, 1);
    #1;
    rrst_n = 1'b0;
    #1;
    check("mid_valid", dout_valid, 0);
    check("mid_rptr", rptr, 5'b00000);
    check("mid_rempty", rempty, 1);
    check("mid_rclken", rclken, 0);
    check("mid_dout", dout, 0);
    @(negedge rclk);
    mem[0] = 8'hD0;
    rrst_n = 1'b1;
    @(negedge rclk);
    exp_w[0] = 8'hD0;
    drain("mid", 1, 10, gaps);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
